// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder.
// Holds the active-low segment pattern constants (bit0 = a ... bit6 = g). They must stay
// bit-identical to the board's hex encoder. Also holds the FSM state type.
package seg7_scan_decoder_pkg;

   localparam int unsigned SEG_W = 7;

   // Active-low patterns: 0 = segment lit.
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Stability counter width; the counter saturates rather than wrapping.
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StTrack,
      StHeld
   } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-7-segment encoder.
// Ports:
//   seg_n  - active-low segment pattern, bit0 = a ... bit6 = g
//   nibble - recovered hex value (0 when the pattern is not a digit)
//   legal  - pattern is one of the sixteen hex glyphs
//   blank  - pattern has every segment off
module seg7_pattern_decode
   import seg7_scan_decoder_pkg::*;
(
   input  logic [SEG_W-1:0] seg_n,
   output logic [3:0]       nibble,
   output logic             legal,
   output logic             blank
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      blank  = 1'b0;
      case (seg_n)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: begin
            legal = 1'b0;
            blank = 1'b1;
         end
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed, active-low 7-segment bus and recovers the displayed hex digits.
// A {seg, dig} sample must stay unchanged for STABLE_CYCLES synchronized samples before it is
// captured. This filters out scan transitions and ghosting.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   seg_n       - segment lines, active-low, bit0 = a ... bit6 = g
//   dig_n       - digit enables, active-low; exactly one low selects a scan slot
//   clr         - clears digit_valid, digit_blank and digit_err
//   digit_bin   - recovered nibbles, digit i at [4i+3:4i]
//   digit_valid - digit holds a legal captured value
//   digit_blank - digit last captured all segments off
//   digit_err   - sticky, digit captured an illegal pattern
//   upd         - one-cycle pulse per capture, upd_idx names the digit
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 16,
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEG_W-1:0]        seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_n,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] digit_bin,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    upd,
   output logic [IdxW-1:0]         upd_idx
);

   localparam logic [CNT_W-1:0] CntCapture = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   // Input synchronizer plus one sample of history for the stability compare.
   // The all-ones reset value reads as "nothing driven", so leaving reset cannot fake a capture.
   logic [SEG_W-1:0]      seg_s1_q, seg_s2_q, seg_prev_q;
   logic [NUM_DIGITS-1:0] dig_s1_q, dig_s2_q, dig_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_s1_q   <= '1;
         seg_s2_q   <= '1;
         seg_prev_q <= '1;
         dig_s1_q   <= '1;
         dig_s2_q   <= '1;
         dig_prev_q <= '1;
      end else begin
         seg_s1_q   <= seg_n;
         seg_s2_q   <= seg_s1_q;
         seg_prev_q <= seg_s2_q;
         dig_s1_q   <= dig_n;
         dig_s2_q   <= dig_s1_q;
         dig_prev_q <= dig_s2_q;
      end
   end

   // Slot check: legal only with exactly one enable low.
   logic [3:0]      zero_cnt;
   logic [IdxW-1:0] slot_idx;
   logic            slot_legal;
   logic            same;

   always_comb begin
      zero_cnt = 4'd0;
      slot_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!dig_s2_q[i]) begin
            zero_cnt = zero_cnt + 4'd1;
            slot_idx = IdxW'(i);
         end
      end
      slot_legal = (zero_cnt == 4'd1);
      same       = ({seg_s2_q, dig_s2_q} == {seg_prev_q, dig_prev_q});
   end

   logic [3:0] dec_nibble;
   logic       dec_legal;
   logic       dec_blank;

   seg7_pattern_decode u_decode (
      .seg_n  (seg_s2_q),
      .nibble (dec_nibble),
      .legal  (dec_legal),
      .blank  (dec_blank)
   );

   // Stability FSM
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             capture;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            if (slot_legal) begin
               state_d = StTrack;
               cnt_d   = '0;
            end
         end
         StTrack: begin
            if (!slot_legal) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CntCapture) begin
                  capture = 1'b1;
                  state_d = StHeld;
               end
            end
         end
         StHeld: begin
            if (!slot_legal) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (!same) begin
               state_d = StTrack;
               cnt_d   = '0;
            end else begin
               // Keeps counting (saturating) but never re-captures until the input changes.
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output registers
   logic [4*NUM_DIGITS-1:0] bin_q, bin_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic                    upd_q, upd_d;
   logic [IdxW-1:0]         upd_idx_q, upd_idx_d;

   always_comb begin
      bin_d     = bin_q;
      valid_d   = valid_q;
      blank_d   = blank_q;
      err_d     = err_q;
      upd_d     = capture;
      upd_idx_d = upd_idx_q;
      // clr first so a simultaneous capture keeps the flags it just set.
      if (clr) begin
         valid_d = '0;
         blank_d = '0;
         err_d   = '0;
      end
      if (capture) begin
         upd_idx_d = slot_idx;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (capture && (slot_idx == IdxW'(i))) begin
            if (dec_legal) begin
               bin_d[4*i +: 4] = dec_nibble;
               valid_d[i]      = 1'b1;
               blank_d[i]      = 1'b0;
            end else if (dec_blank) begin
               valid_d[i] = 1'b0;
               blank_d[i] = 1'b1;
            end else begin
               err_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q     <= '0;
         valid_q   <= '0;
         blank_q   <= '0;
         err_q     <= '0;
         upd_q     <= 1'b0;
         upd_idx_q <= '0;
      end else begin
         bin_q     <= bin_d;
         valid_q   <= valid_d;
         blank_q   <= blank_d;
         err_q     <= err_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
      end
   end

   assign digit_bin   = bin_q;
   assign digit_valid = valid_q;
   assign digit_blank = blank_q;
   assign digit_err   = err_q;
   assign upd         = upd_q;
   assign upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed, table-driven bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=16).
module tb_seg7_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic        clr;
   logic [15:0] digit_bin;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_blank;
   logic [3:0]  digit_err;
   logic        upd;
   logic [1:0]  upd_idx;

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .dig_n       (dig_n),
      .clr         (clr),
      .digit_bin   (digit_bin),
      .digit_valid (digit_valid),
      .digit_blank (digit_blank),
      .digit_err   (digit_err),
      .upd         (upd),
      .upd_idx     (upd_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   int upd_cnt  = 0;
   int last_upd_edge = -1;
   int last_upd_idx  = -1;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      if (upd === 1'b1) begin
         upd_cnt       <= upd_cnt + 1;
         last_upd_edge <= edge_cnt;
         last_upd_idx  <= int'(upd_idx);
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Each step moves to the next cycle, 1 time unit after the falling edge.
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  dig;
      logic [6:0]  seg;
      int          hold;
      int          upds;
      logic [15:0] bin;
      logic [3:0]  valid;
      logic [3:0]  blank;
      logic [3:0]  err;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int u0;
      int e0;

      vecs[0] = '{4'b1110, 7'b0001000, 32, 1, 16'h000A, 4'b0001, 4'b0000, 4'b0000}; // A
      vecs[1] = '{4'b1101, 7'b0000011, 32, 1, 16'h00BA, 4'b0011, 4'b0000, 4'b0000}; // b
      vecs[2] = '{4'b1011, 7'b1000110, 32, 1, 16'h0CBA, 4'b0111, 4'b0000, 4'b0000}; // C
      vecs[3] = '{4'b0111, 7'b0100001, 32, 1, 16'hDCBA, 4'b1111, 4'b0000, 4'b0000}; // d
      vecs[4] = '{4'b1100, 7'b0000000, 32, 0, 16'hDCBA, 4'b1111, 4'b0000, 4'b0000}; // two slots
      vecs[5] = '{4'b1110, 7'b1111111, 32, 1, 16'hDCBA, 4'b1110, 4'b0001, 4'b0000}; // blank
      vecs[6] = '{4'b1011, 7'b1111110, 32, 1, 16'hDCBA, 4'b1110, 4'b0001, 4'b0100}; // illegal
      vecs[7] = '{4'b1110, 7'b0010010, 20, 1, 16'hDCB5, 4'b1111, 4'b0000, 4'b0100}; // 5
      vecs[8] = '{4'b1101, 7'b0000000, 10, 0, 16'hDCB5, 4'b1111, 4'b0000, 4'b0100}; // glitch
      vecs[9] = '{4'b1101, 7'b0010000, 20, 1, 16'hDC95, 4'b1111, 4'b0000, 4'b0100}; // 9

      // Reset with random inputs
      rst_n = 1'b0;
      clr   = 1'b0;
      seg_n = 7'($urandom);
      dig_n = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         seg_n = 7'($urandom);
         dig_n = 4'($urandom);
      end
      check("reset bin", 32'(digit_bin), 32'h0);
      check("reset valid", 32'(digit_valid), 32'h0);
      check("reset blank", 32'(digit_blank), 32'h0);
      check("reset err", 32'(digit_err), 32'h0);
      check("reset upd_idx", 32'(upd_idx), 32'h0);
      check("reset upd count", 32'(upd_cnt), 32'h0);
      seg_n = 7'b1111111;
      dig_n = 4'b1111;
      rst_n = 1'b1;
      cycles(3);

      // Single digit: upd 18 cycles after the new value reaches the pins
      u0 = upd_cnt;
      e0 = edge_cnt;
      dig_n = 4'b1110;
      seg_n = 7'b0100100;
      cycles(20);
      check("single upd count", 32'(upd_cnt - u0), 32'd1);
      check("single upd cycle", 32'(last_upd_edge - e0), 32'd18);
      check("single upd_idx", 32'(last_upd_idx), 32'd0);
      check("single bin", 32'(digit_bin), 32'h0002);
      check("single valid", 32'(digit_valid), 32'b0001);

      // Table: full scan, illegal slot, blank, illegal pattern, glitch
      for (int v = 0; v < 10; v++) begin
         u0 = upd_cnt;
         dig_n = vecs[v].dig;
         seg_n = vecs[v].seg;
         cycles(vecs[v].hold);
         check($sformatf("vec%0d upd count", v), 32'(upd_cnt - u0), 32'(vecs[v].upds));
         check($sformatf("vec%0d bin", v), 32'(digit_bin), 32'(vecs[v].bin));
         check($sformatf("vec%0d valid", v), 32'(digit_valid), 32'(vecs[v].valid));
         check($sformatf("vec%0d blank", v), 32'(digit_blank), 32'(vecs[v].blank));
         check($sformatf("vec%0d err", v), 32'(digit_err), 32'(vecs[v].err));
      end

      // clr with inputs steady (no capture pending)
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(1);
      check("clr err", 32'(digit_err), 32'h0);
      check("clr valid", 32'(digit_valid), 32'h0);
      check("clr blank", 32'(digit_blank), 32'h0);
      check("clr keeps bin", 32'(digit_bin), 32'hDC95);

      // Reset mid-TRACK after 10 stable cycles
      dig_n = 4'b1101;
      seg_n = 7'b0110000;
      cycles(10);
      u0 = upd_cnt;
      rst_n = 1'b0;
      cycles(2);
      check("midrst bin", 32'(digit_bin), 32'h0);
      check("midrst valid", 32'(digit_valid), 32'h0);
      check("midrst err", 32'(digit_err), 32'h0);
      rst_n = 1'b1;
      e0 = edge_cnt;
      cycles(20);
      check("midrst upd count", 32'(upd_cnt - u0), 32'd1);
      check("midrst upd cycle", 32'(last_upd_edge - e0), 32'd18);
      check("midrst bin after", 32'(digit_bin), 32'h0030);
      check("midrst valid after", 32'(digit_valid), 32'b0010);

      // Digit 0 = 7, then clr coincident with a capture of 4 on digit 1
      dig_n = 4'b1110;
      seg_n = 7'b1111000;
      cycles(20);
      check("pre-clr valid", 32'(digit_valid), 32'b0011);
      u0 = upd_cnt;
      e0 = edge_cnt;
      dig_n = 4'b1101;
      seg_n = 7'b0011001;
      cycles(17);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(2);
      check("coinc upd count", 32'(upd_cnt - u0), 32'd1);
      check("coinc upd cycle", 32'(last_upd_edge - e0), 32'd18);
      check("coinc upd_idx", 32'(last_upd_idx), 32'd1);
      check("coinc valid", 32'(digit_valid), 32'b0010);
      check("coinc bin", 32'(digit_bin), 32'h0047);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
